// File: rtl/branch_unwinder_pkg.sv
// Shared control-stack frame layout, request/frame encodings and unwinder state type.
package branch_unwinder_pkg;

    localparam int unsigned CS_W = 15;

    typedef enum logic [1:0] {
        KIND_END = 2'b00,
        KIND_BR  = 2'b01,
        KIND_RET = 2'b10,
        KIND_RSV = 2'b11
    } req_kind_e;

    typedef enum logic [1:0] {
        FT_BLOCK = 2'b00,
        FT_CALL  = 2'b01,
        FT_IF    = 2'b10,
        FT_LOOP  = 2'b11
    } frame_type_e;

    // [14:13] frame_type, [12] retu_num, [11:8] sp_tag, [7:0] retu_addr
    typedef struct packed {
        frame_type_e frame_type;
        logic        retu_num;
        logic [3:0]  sp_tag;
        logic [7:0]  retu_addr;
    } cs_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UNWIND,
        ST_DONE
    } uw_state_e;

endpackage

// File: rtl/branch_unwinder_if.sv
// Decode-side request/completion bundle of the branch unwinder.
interface branch_unwinder_if #(
    parameter int unsigned DEPTH_W = 4
);
    logic               req_valid;
    logic [1:0]         req_kind;
    logic [DEPTH_W-1:0] req_depth;
    logic               req_ready;
    logic               done_valid;
    logic               jump_en;
    logic [7:0]         jump_addr;
    logic [3:0]         sp_tag;
    logic               retu_num;
    logic               halt;
    logic               err;

    modport master (
        output req_valid, req_kind, req_depth,
        input  req_ready, done_valid, jump_en, jump_addr, sp_tag, retu_num, halt, err
    );

    modport slave (
        input  req_valid, req_kind, req_depth,
        output req_ready, done_valid, jump_en, jump_addr, sp_tag, retu_num, halt, err
    );
endinterface

// File: rtl/branch_unwinder.sv
// Unwinds the control stack for end/br/return, one frame per cycle, and reports
// the resolving frame with a single-cycle completion pulse.
module branch_unwinder
    import branch_unwinder_pkg::*;
#(
    parameter int unsigned DEPTH_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_unwinder_if.slave bus,
    output logic            cs_pop,
    input  logic [CS_W-1:0] cs_top_data,
    input  logic            cs_left_one
);

    uw_state_e          state_q, state_d;
    req_kind_e          kind_r, kind_d;
    logic [DEPTH_W-1:0] remain_r, remain_d;
    logic               jump_en_r, jump_en_d;
    logic               halt_r, halt_d;
    logic               err_r, err_d;
    logic               cap;
    logic [7:0]         jump_addr_r;
    logic [3:0]         sp_tag_r;
    logic               retu_num_r;
    cs_frame_t          top;
    logic               is_call;

    assign top     = cs_frame_t'(cs_top_data);
    assign is_call = (top.frame_type == FT_CALL);

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_r;
        remain_d  = remain_r;
        jump_en_d = jump_en_r;
        halt_d    = halt_r;
        err_d     = err_r;
        cs_pop    = 1'b0;
        cap       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    kind_d    = req_kind_e'(bus.req_kind);
                    remain_d  = bus.req_depth;
                    jump_en_d = 1'b0;
                    halt_d    = 1'b0;
                    err_d     = (bus.req_kind == KIND_RSV);
                    state_d   = (bus.req_kind == KIND_RSV) ? ST_DONE : ST_UNWIND;
                end
            end
            ST_UNWIND: begin
                unique case (kind_r)
                    KIND_END: begin
                        cs_pop    = 1'b1;
                        cap       = 1'b1;
                        state_d   = ST_DONE;
                        jump_en_d = is_call;
                        halt_d    = is_call && cs_left_one;
                    end
                    KIND_BR: begin
                        if (remain_r != '0) begin
                            cs_pop = 1'b1;
                            if (cs_left_one) begin
                                cap     = 1'b1;
                                state_d = ST_DONE;
                                err_d   = 1'b1;
                            end else begin
                                remain_d = remain_r - 1'b1;
                            end
                        end else begin
                            // Loop target re-enters its body, so its frame stays on the stack.
                            cs_pop    = (top.frame_type != FT_LOOP);
                            cap       = 1'b1;
                            state_d   = ST_DONE;
                            jump_en_d = (top.frame_type == FT_LOOP) || is_call;
                            halt_d    = is_call && cs_left_one;
                        end
                    end
                    KIND_RET: begin
                        cs_pop = 1'b1;
                        if (is_call) begin
                            cap       = 1'b1;
                            state_d   = ST_DONE;
                            jump_en_d = 1'b1;
                            halt_d    = cs_left_one;
                        end else if (cs_left_one) begin
                            cap     = 1'b1;
                            state_d = ST_DONE;
                            err_d   = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                endcase
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kind_r      <= KIND_END;
            remain_r    <= '0;
            jump_en_r   <= 1'b0;
            halt_r      <= 1'b0;
            err_r       <= 1'b0;
            jump_addr_r <= '0;
            sp_tag_r    <= '0;
            retu_num_r  <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_r    <= kind_d;
            remain_r  <= remain_d;
            jump_en_r <= jump_en_d;
            halt_r    <= halt_d;
            err_r     <= err_d;
            if (cap) begin
                jump_addr_r <= top.retu_addr;
                sp_tag_r    <= top.sp_tag;
                retu_num_r  <= top.retu_num;
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.done_valid = (state_q == ST_DONE);
    assign bus.jump_en    = (state_q == ST_DONE) && jump_en_r;
    assign bus.halt       = (state_q == ST_DONE) && halt_r;
    assign bus.err        = (state_q == ST_DONE) && err_r;
    assign bus.jump_addr  = jump_addr_r;
    assign bus.sp_tag     = sp_tag_r;
    assign bus.retu_num   = retu_num_r;

endmodule

// File: tb/tb_branch_unwinder.sv
// Bench for branch_unwinder: directed table, corner sequences and random requests
// against a frame-index reference model over a behavioural control stack.
module tb_branch_unwinder;
    import branch_unwinder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_pop;
    logic [CS_W-1:0] cs_top_data;
    logic cs_left_one;

    branch_unwinder_if #(.DEPTH_W(4)) bus();

    branch_unwinder #(.DEPTH_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cs_pop(cs_pop), .cs_top_data(cs_top_data), .cs_left_one(cs_left_one)
    );

    always #5 clk = ~clk;

    // Behavioural control stack: contents in stk_mem, depth in stk_cnt.
    logic [14:0] stk_mem [16];
    int stk_cnt = 0;
    int pop_cnt = 0;
    int load_cnt = 0;
    logic load_go = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stk_cnt <= 0;
        else if (load_go) stk_cnt <= load_cnt;
        else if (cs_pop && stk_cnt > 0) begin
            stk_cnt <= stk_cnt - 1;
            pop_cnt <= pop_cnt + 1;
        end
    end
    always_comb begin
        cs_top_data = '0;
        if (stk_cnt > 0) cs_top_data = stk_mem[stk_cnt-1];
    end
    assign cs_left_one = (stk_cnt == 1);

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int pops; int lat; logic je; logic [7:0] addr; logic [3:0] tag;
        logic rn; logic halt; logic err;
    } exp_t;

    typedef struct {
        int n; logic [59:0] f; logic [1:0] kind; int depth; exp_t e; logic chk_f;
    } row_t;

    int obs_lat, obs_pops;
    logic obs_to, obs_je, obs_rn, obs_halt, obs_err, obs_rdy, obs_pop_done;
    logic [7:0] obs_addr;
    logic [3:0] obs_tag;

    function automatic logic [14:0] fr(logic [1:0] ty, logic rn, logic [3:0] tag, logic [7:0] addr);
        return {ty, rn, tag, addr};
    endfunction

    function automatic exp_t ex(int pops, int lat, logic je, logic [7:0] a, logic [3:0] t,
                                logic rn, logic h, logic e);
        exp_t r;
        r.pops = pops; r.lat = lat; r.je = je; r.addr = a; r.tag = t;
        r.rn = rn; r.halt = h; r.err = e;
        return r;
    endfunction

    function automatic row_t mk(int n, logic [59:0] f, logic [1:0] k, int d, exp_t e, logic cf);
        row_t r;
        r.n = n; r.f = f; r.kind = k; r.depth = d; r.e = e; r.chk_f = cf;
        return r;
    endfunction

    // Reference: locate the resolving frame by index arithmetic over the stack snapshot.
    function automatic exp_t model(int cnt, logic [1:0] kind, int depth);
        exp_t e;
        int idx;
        logic [14:0] f;
        e = ex(0, 0, 1'b0, 8'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        idx = -1;
        if (kind == 2'b11) begin
            e.lat = 1; e.err = 1'b1;
            return e;
        end
        if (kind == 2'b00) begin
            idx = cnt - 1;
            e.pops = 1; e.lat = 2;
            f = stk_mem[idx];
            e.je = (f[14:13] == FT_CALL);
            e.halt = e.je && (cnt == 1);
        end else if (kind == 2'b01) begin
            if (depth < cnt) begin
                idx = cnt - 1 - depth;
                f = stk_mem[idx];
                e.lat = depth + 2;
                e.pops = (f[14:13] == FT_LOOP) ? depth : depth + 1;
                e.je = (f[14:13] == FT_LOOP) || (f[14:13] == FT_CALL);
                e.halt = (f[14:13] == FT_CALL) && (idx == 0);
            end
        end else begin
            for (int c = cnt - 1; c >= 0 && idx < 0; c--) begin
                f = stk_mem[c];
                if (f[14:13] == FT_CALL) idx = c;
            end
            if (idx >= 0) begin
                e.pops = cnt - idx; e.lat = e.pops + 1; e.je = 1'b1; e.halt = (idx == 0);
            end
        end
        if (idx < 0) begin
            e.err = 1'b1; e.pops = cnt; e.lat = cnt + 1;
        end else begin
            f = stk_mem[idx];
            e.rn = f[12]; e.tag = f[11:8]; e.addr = f[7:0];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cnt(input int n);
        load_cnt = n;
        load_go = 1'b1;
        @(negedge clk);
        load_go = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run(input logic [1:0] kind, input int depth, input bit hold);
        int p0;
        bus.req_valid = 1'b1;
        bus.req_kind = kind;
        bus.req_depth = 4'(depth);
        obs_rdy = bus.req_ready;
        p0 = pop_cnt;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        obs_lat = 1;
        while (!bus.done_valid && obs_lat < 40) begin
            @(negedge clk);
            obs_lat++;
        end
        obs_to = !bus.done_valid;
        obs_je = bus.jump_en; obs_halt = bus.halt; obs_err = bus.err;
        obs_addr = bus.jump_addr; obs_tag = bus.sp_tag; obs_rn = bus.retu_num;
        obs_pop_done = cs_pop;
        obs_pops = pop_cnt - p0;
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic cf);
        chk({nm, ".timeout"}, 32'(obs_to), 32'd0);
        chk({nm, ".ready"}, 32'(obs_rdy), 32'd1);
        chk({nm, ".latency"}, 32'(obs_lat), 32'(e.lat));
        chk({nm, ".pops"}, 32'(obs_pops), 32'(e.pops));
        chk({nm, ".pop_in_done"}, 32'(obs_pop_done), 32'd0);
        chk({nm, ".jump_en"}, 32'(obs_je), 32'(e.je));
        chk({nm, ".halt"}, 32'(obs_halt), 32'(e.halt));
        chk({nm, ".err"}, 32'(obs_err), 32'(e.err));
        if (cf) begin
            chk({nm, ".jump_addr"}, 32'(obs_addr), 32'(e.addr));
            chk({nm, ".sp_tag"}, 32'(obs_tag), 32'(e.tag));
            chk({nm, ".retu_num"}, 32'(obs_rn), 32'(e.rn));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[10];
        exp_t e;
        int cnt, depth, r, p0;
        logic [1:0] kind;
        logic [59:0] fv;

        bus.req_valid = 1'b0;
        bus.req_kind = 2'b00;
        bus.req_depth = '0;

        // Frames listed top-first in each 60-bit concat; n=0 keeps the current stack.
        rows[0] = mk(3, {15'h0, fr(FT_BLOCK,0,4'h7,8'h31), fr(FT_BLOCK,0,4'h5,8'h30), fr(FT_CALL,0,4'h1,8'h10)},
                     2'b01, 1, ex(2, 3, 0, 8'h30, 4'h5, 0, 0, 0), 1'b1);
        rows[1] = mk(3, {15'h0, fr(FT_BLOCK,0,4'h6,8'h40), fr(FT_LOOP,1,4'h3,8'h20), fr(FT_CALL,0,4'h1,8'h10)},
                     2'b01, 1, ex(1, 3, 1, 8'h20, 4'h3, 1, 0, 0), 1'b1);
        rows[2] = mk(4, {fr(FT_BLOCK,0,4'h5,8'h60), fr(FT_IF,0,4'h4,8'h50), fr(FT_CALL,1,4'h2,8'h44), fr(FT_CALL,0,4'h0,8'h10)},
                     2'b10, 0, ex(3, 4, 1, 8'h44, 4'h2, 1, 0, 0), 1'b1);
        rows[3] = mk(0, 60'h0, 2'b10, 0, ex(1, 2, 1, 8'h10, 4'h0, 0, 1, 0), 1'b1);
        rows[4] = mk(1, {45'h0, fr(FT_BLOCK,0,4'h9,8'h70)},
                     2'b01, 3, ex(1, 2, 0, 8'h0, 4'h0, 0, 0, 1), 1'b0);
        rows[5] = mk(2, {30'h0, fr(FT_BLOCK,1,4'h4,8'h22), fr(FT_CALL,0,4'h1,8'h10)},
                     2'b00, 0, ex(1, 2, 0, 8'h22, 4'h4, 1, 0, 0), 1'b1);
        rows[6] = mk(1, {45'h0, fr(FT_CALL,1,4'h8,8'h33)},
                     2'b00, 0, ex(1, 2, 1, 8'h33, 4'h8, 1, 1, 0), 1'b1);
        rows[7] = mk(2, {30'h0, fr(FT_CALL,0,4'h6,8'h55), fr(FT_CALL,0,4'h1,8'h10)},
                     2'b01, 0, ex(1, 2, 1, 8'h55, 4'h6, 0, 0, 0), 1'b1);
        rows[8] = mk(2, {30'h0, fr(FT_LOOP,0,4'h2,8'h21), fr(FT_BLOCK,0,4'h1,8'h11)},
                     2'b10, 0, ex(2, 3, 0, 8'h0, 4'h0, 0, 0, 1), 1'b0);
        rows[9] = mk(3, {15'h0, fr(FT_IF,0,4'h3,8'h03), fr(FT_LOOP,0,4'h2,8'h02), fr(FT_BLOCK,0,4'h1,8'h01)},
                     2'b01, 15, ex(3, 4, 0, 8'h0, 4'h0, 0, 0, 1), 1'b0);

        #1;
        chk("reset.ready", 32'(bus.req_ready), 32'd1);
        chk("reset.outputs", {26'd0, cs_pop, bus.done_valid, bus.jump_en, bus.halt, bus.err, bus.retu_num}, 32'd0);
        chk("reset.fields", {20'd0, bus.jump_addr, bus.sp_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (rows[i].n > 0) begin
                fv = rows[i].f;
                for (int j = 0; j < 4; j++) stk_mem[j] = fv[j*15 +: 15];
                set_cnt(rows[i].n);
            end
            run(rows[i].kind, rows[i].depth, 1'b0);
            cmp($sformatf("row%0d", i), rows[i].e, rows[i].chk_f);
        end

        // req_valid held through the unwind: only the first request is serviced.
        stk_mem[0] = fr(FT_CALL, 0, 4'h1, 8'h10);
        stk_mem[1] = fr(FT_BLOCK, 0, 4'h5, 8'h30);
        stk_mem[2] = fr(FT_BLOCK, 0, 4'h7, 8'h31);
        set_cnt(3);
        run(2'b01, 1, 1'b1);
        cmp("hold", ex(2, 3, 0, 8'h30, 4'h5, 0, 0, 0), 1'b1);
        p0 = pop_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold.no_extra_done", 32'(bus.done_valid), 32'd0);
        end
        chk("hold.no_extra_pops", 32'(pop_cnt - p0), 32'd0);

        run(2'b11, 0, 1'b0);
        cmp("reserved", ex(0, 1, 0, 8'h0, 4'h0, 0, 0, 1), 1'b0);

        for (int t = 0; t < 60; t++) begin
            cnt = $urandom_range(1, 8);
            for (int j = 0; j < cnt; j++)
                stk_mem[j] = fr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            set_cnt(cnt);
            r = $urandom_range(0, 9);
            kind = (r == 0) ? 2'b11 : (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
            depth = $urandom_range(0, cnt + 1);
            if (depth > 15) depth = 15;
            e = model(cnt, kind, depth);
            run(kind, depth, 1'b0);
            cmp($sformatf("rand%0d", t), e, !e.err && kind != 2'b11);
        end

        // Reset in the middle of a deep br unwind.
        for (int j = 0; j < 8; j++) stk_mem[j] = fr(FT_BLOCK, 0, 4'(j), 8'(8'h80 + j));
        set_cnt(8);
        bus.req_valid = 1'b1;
        bus.req_kind = 2'b01;
        bus.req_depth = 4'd5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midreset.popping", 32'(cs_pop), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset.pop", 32'(cs_pop), 32'd0);
        chk("midreset.ready", 32'(bus.req_ready), 32'd1);
        chk("midreset.outputs", {27'd0, bus.done_valid, bus.jump_en, bus.halt, bus.err, bus.retu_num}, 32'd0);
        chk("midreset.fields", {20'd0, bus.jump_addr, bus.sp_tag}, 32'd0);
        @(negedge clk);
        chk("midreset.held", {30'd0, cs_pop, bus.done_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
